// File: rtl/eth_tx_pkg.sv
// Shared definitions for the Ethernet transmit path: framer state encoding
// and the default frame-size / inter-frame-gap limits.
package eth_tx_pkg;

  localparam int DEF_MIN_LEN = 60;    // shortest frame on the wire, in beats
  localparam int DEF_MAX_LEN = 1514;  // longest legal payload, in beats
  localparam int DEF_IFG     = 2;     // idle cycles forced after each frame

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_PAD,
    ST_GAP
  } tx_state_t;

endpackage

// File: rtl/tx_skid_reg.sv
// Two-entry skid register. Holds buffer read data that is already in flight
// when the MAC stalls; entry 0 is the beat currently presented downstream.
module tx_skid_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] ent0;
  logic [DATA_W-1:0] ent1;

  // Entry storage: shift on pop, fill the first free slot on push.
  // NOTE: the entries are deliberately not reset; the occupancy count is, and
  // the framer masks the data output whenever the register is empty.
  always_ff @(posedge clk) begin
    if (pop) begin
      if (push && (count == 2'd1)) ent0 <= push_data;
      else                         ent0 <= ent1;
      if (push)                    ent1 <= push_data;
    end else if (push) begin
      if (count == 2'd0) ent0 <= push_data;
      else               ent1 <= push_data;
    end
  end

  // Occupancy: the caller never pops when empty or pushes when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            count <= 2'd0;
    else if (push && !pop) count <= count + 2'd1;
    else if (pop && !push) count <= count - 2'd1;
  end

  assign head = ent0;

endmodule

// File: rtl/tx_framer.sv
// Transmit framer: pulls payload beats from a buffer, streams them to the MAC
// with ready/valid flow control, optionally zero-pads short frames up to
// MIN_LEN, then enforces an inter-frame gap.
module tx_framer
  import eth_tx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 16,
  parameter int MIN_LEN = DEF_MIN_LEN,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int IFG     = DEF_IFG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frm_start,
  input  logic [LEN_W-1:0]  frm_len,
  input  logic              pad_en,
  input  logic [DATA_W-1:0] buf_data,
  input  logic              buf_empty,
  output logic              buf_rd,
  input  logic              tx_mac_ready,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              valid_flag,
  output logic              last_byte,
  output logic              busy,
  output logic              frm_done,
  output logic              frm_err
);

  tx_state_t         state, state_nx;
  logic [LEN_W-1:0]  len_q, rd_cnt, sent_cnt;
  logic              pad_q, rd_q, err_q;
  logic [7:0]        gap_cnt;
  logic [1:0]        occ;
  logic [DATA_W-1:0] head;
  logic [2:0]        fill;
  logic              legal, xfer, skid_pop, do_pad, pay_last, pad_last;

  // Data returned by the buffer one cycle after each pop lands in the skid.
  tx_skid_reg #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst),
    .push      (rd_q),
    .push_data (buf_data),
    .pop       (skid_pop),
    .head      (head),
    .count     (occ)
  );

  // Output beat, transfer handshake and buffer read credit.
  always_comb begin
    legal      = (frm_len != '0) && (frm_len <= LEN_W'(MAX_LEN));
    do_pad     = pad_q && (len_q < LEN_W'(MIN_LEN));
    pay_last   = (sent_cnt == len_q - LEN_W'(1));
    pad_last   = (sent_cnt == LEN_W'(MIN_LEN - 1));
    valid_flag = ((state == ST_SEND) && (occ != 2'd0)) || (state == ST_PAD);
    last_byte  = ((state == ST_SEND) && (occ != 2'd0) && pay_last && !do_pad) ||
                 ((state == ST_PAD) && pad_last);
    tx_data_o  = ((state == ST_SEND) && (occ != 2'd0)) ? head : '0;
    xfer       = valid_flag && tx_mac_ready;
    skid_pop   = xfer && (state == ST_SEND);
    // Entries held after this edge including the read in flight; a new read
    // is safe only if its data will still find a free slot.
    fill       = 3'(occ) + 3'(rd_q) - 3'(skid_pop);
    buf_rd     = (state == ST_SEND) && !buf_empty && (rd_cnt < len_q) && (fill <= 3'd1);
    frm_done   = xfer && last_byte;
    busy       = (state != ST_IDLE);
    frm_err    = err_q;
  end

  // Next-state selection.
  // NOTE: state_nx gets a default first so no branch leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (frm_start && legal)   state_nx = ST_SEND;
      ST_SEND: if (skid_pop && pay_last) state_nx = do_pad ? ST_PAD : ST_GAP;
      ST_PAD:  if (xfer && pad_last)     state_nx = ST_GAP;
      ST_GAP:  if (gap_cnt == 8'(IFG - 1)) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Request latch, beat counters, gap timer and error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q    <= '0;
      pad_q    <= 1'b0;
      rd_cnt   <= '0;
      sent_cnt <= '0;
      rd_q     <= 1'b0;
      err_q    <= 1'b0;
      gap_cnt  <= 8'd0;
    end else begin
      rd_q  <= buf_rd;
      err_q <= (state == ST_IDLE) && frm_start && !legal;
      if ((state == ST_IDLE) && frm_start && legal) begin
        len_q    <= frm_len;
        pad_q    <= pad_en;
        rd_cnt   <= '0;
        sent_cnt <= '0;
      end else begin
        if (buf_rd) rd_cnt   <= rd_cnt + LEN_W'(1);
        if (xfer)   sent_cnt <= sent_cnt + LEN_W'(1);
      end
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 8'd1 : 8'd0;
    end
  end

endmodule

// File: doc/tx_framer.md
TX_FRAMER -- requirements
Module: tx_framer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, output/buffer byte-lane width in bits.
REQ-002 SHALL have parameter LEN_W, default 16, width of frame-length fields and counters.
REQ-003 SHALL have parameter MIN_LEN, default 60, minimum emitted frame length in beats when padding is enabled.
REQ-004 SHALL have parameter MAX_LEN, default 1514, largest legal frm_len.
REQ-005 SHALL have parameter IFG, default 2, idle cycles forced after each last beat (range 1..255).
REQ-006 SHALL have port clk, input, 1, single clock; all logic on the rising edge.
REQ-007 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port frm_start, input, 1, one-cycle request to send a frame.
REQ-009 SHALL have port frm_len, input, LEN_W, payload length in beats, sampled with frm_start.
REQ-010 SHALL have port pad_en, input, 1, pad-to-MIN_LEN enable, sampled with frm_start.
REQ-011 SHALL have port buf_data, input, DATA_W, buffer read data, valid one cycle after buf_rd.
REQ-012 SHALL have port buf_empty, input, 1, buffer has no data.
REQ-013 SHALL have port buf_rd, output, 1, buffer pop strobe (replaces nextByte).
REQ-014 SHALL have port tx_mac_ready, input, 1, MAC accepts the current beat.
REQ-015 SHALL have port tx_data_o, output, DATA_W, beat data to the MAC.
REQ-016 SHALL have port valid_flag, output, 1, tx_data_o is valid.
REQ-017 SHALL have port last_byte, output, 1, current beat is the final beat of the frame.
REQ-018 SHALL have port busy, output, 1, a frame or the IFG is in progress.
REQ-019 SHALL have port frm_done, output, 1, one-cycle pulse when the last beat transfers.
REQ-020 SHALL have port frm_err, output, 1, one-cycle pulse on rejection of an illegal request.

Function
REQ-021 SHALL transfer a beat only in a cycle where valid_flag and tx_mac_ready are both 1.
REQ-022 SHALL hold tx_data_o, valid_flag and last_byte stable while valid_flag=1 and tx_mac_ready=0.
REQ-023 SHALL implement states IDLE, SEND, PAD and GAP.
REQ-024 SHALL, in IDLE on frm_start with 1<=frm_len<=MAX_LEN, latch frm_len and pad_en, set busy and enter SEND next cycle.
REQ-025 SHALL, in IDLE on frm_start with frm_len=0 or frm_len>MAX_LEN, pulse frm_err, stay in IDLE and leave busy=0.
REQ-026 SHALL ignore frm_start while busy=1.
REQ-027 SHALL assert buf_rd only when buf_empty=0, payload beats remain unrequested, and the output/skid storage can accept data one cycle later.
REQ-028 SHALL never assert buf_rd more than frm_len times per frame.
REQ-029 SHALL sustain one beat per cycle when the buffer is non-empty and tx_mac_ready is held at 1.
REQ-030 SHALL, on buffer underrun mid-payload, deassert valid_flag (bubble) without error and resume when data arrives.
REQ-031 SHALL, after the final payload beat, enter PAD when the latched pad_en=1 and frm_len<MIN_LEN; otherwise the final payload beat SHALL carry last_byte=1.
REQ-032 SHALL, in PAD, emit MIN_LEN-frm_len beats of zero with valid_flag=1 and last_byte=1 on the final pad beat.
REQ-033 SHALL use LEN_W-bit beat counters with no wrap; the comparison against MIN_LEN SHALL be unsigned.
REQ-034 SHALL, on the last-beat transfer, pulse frm_done and enter GAP for IFG cycles, then return to IDLE and clear busy.
REQ-035 SHALL keep valid_flag=0 in IDLE and GAP.

Reset
REQ-036 SHALL, when rst=0, immediately force IDLE, all counters to 0, tx_data_o=0, and valid_flag, last_byte, buf_rd, busy, frm_done and frm_err to 0.
REQ-037 SHALL abandon a frame when reset occurs mid-frame, without a frm_done pulse; draining the buffer is the upstream responsibility.

Structure
REQ-038 SHALL take the state enum, the MIN_LEN/MAX_LEN defaults and the IFG default from shared package eth_tx_pkg.
REQ-039 SHALL contain one sub-module, tx_skid_reg, a 2-entry skid holding buffer read data under backpressure.

Verification
REQ-040 SHALL cover: frm_len=64, pad_en=1, ready=1, buffer full -> 64 beats on consecutive cycles, last on beat 64, frm_done, busy low 2 cycles later.
REQ-041 SHALL cover: frm_len=10, pad_en=1 -> 10 data beats then 50 zero beats, last on beat 60.
REQ-042 SHALL cover: frm_len=10, pad_en=0 -> 10 beats, last on beat 10, no padding.
REQ-043 SHALL cover: ready toggling 1/0 every cycle with frm_len=20 -> data held during stalls, 20 beats in order, exactly 20 buf_rd pulses.
REQ-044 SHALL cover: frm_len=0 and frm_len=1515 -> frm_err pulse, busy=0, no valid_flag.
REQ-045 SHALL cover: rst asserted at beat 5 of 64 -> all outputs 0 asynchronously; a new frm_len=64 request after release completes normally.
